avl_burst_mem_slave: RTL and testbench

Avalon-MM burst-capable memory responder: the slave end of the burst-read protocol issued by the instruction cache refill logic (and, for writes, by future data-side masters). Holds a word-addressed on-chip array, answers read bursts with a fixed, configurable initial latency followed by back-to-back `av_readdatavalid` beats, and accepts write bursts beat by beat. Sits on the memory side of the cache's Avalon master port, in place of (or in front of) external memory in simulation and on-chip builds.

---
 rtl/avl_burst_mem_slave.sv | 156 +++++++++++++++
 tb/tb_avl_burst_mem_slave.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avl_burst_mem_slave.sv
// Avalon-MM burst memory responder: word-addressed on-chip array serving read bursts
// after a fixed initial latency and accepting write bursts beat by beat.
module avl_burst_mem_slave #(
    parameter int    DEPTH_WORDS  = 4096,
    parameter int    INIT_LATENCY = 2,
    parameter string INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] av_address,
    input  logic        av_read,
    input  logic        av_write,
    input  logic [31:0] av_writedata,
    input  logic [4:0]  av_burstcount,
    output logic        av_waitrequest,
    output logic [31:0] av_readdata,
    output logic        av_readdatavalid,
    output logic        protocol_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_RELOAD = (INIT_LATENCY > 1) ? 4'(INIT_LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        READ_LAT,
        READ_BURST,
        WRITE_BURST
    } state_t;

    state_t         state_q, state_nxt;
    logic [AW-1:0]  addr_q, addr_nxt;
    logic [4:0]     count_q, count_nxt;
    logic [3:0]     lat_q, lat_nxt;
    logic           err_q, err_nxt;
    logic           loaded_q, loaded_nxt;

    logic [31:0]    mem [DEPTH_WORDS];
    logic [31:0]    mem_q;
    logic           mem_we;
    logic           mem_re;
    logic [AW-1:0]  mem_addr;

    logic [AW-1:0]  cmd_idx;
    logic [4:0]     cmd_n;
    logic           unused_addr_bits;

    assign cmd_idx          = av_address[AW+1:2];
    assign cmd_n            = (av_burstcount == 5'd0) ? 5'd1 : av_burstcount;
    assign unused_addr_bits = ^{av_address[31:AW+2], av_address[1:0]};

    // Single-port array; the read data register feeds av_readdata and only
    // updates on a beat, so the last beat is held between bursts.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_addr] <= av_writedata;
        if (mem_re)
            mem_q <= mem[mem_addr];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            count_q  <= '0;
            lat_q    <= '0;
            err_q    <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            addr_q   <= addr_nxt;
            count_q  <= count_nxt;
            lat_q    <= lat_nxt;
            err_q    <= err_nxt;
            loaded_q <= loaded_nxt;
        end
    end

    // count_q holds the beats still to come after the current one.
    always_comb begin
        state_nxt  = state_q;
        addr_nxt   = addr_q;
        count_nxt  = count_q;
        lat_nxt    = lat_q;
        err_nxt    = err_q;
        loaded_nxt = loaded_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = addr_q;

        case (state_q)
            IDLE: begin
                if (av_read) begin
                    err_nxt   = err_q | av_write;
                    count_nxt = cmd_n - 5'd1;
                    if (INIT_LATENCY <= 1) begin
                        mem_re     = 1'b1;
                        mem_addr   = cmd_idx;
                        loaded_nxt = 1'b1;
                        addr_nxt   = cmd_idx + AW'(1);
                        state_nxt  = READ_BURST;
                    end else begin
                        addr_nxt  = cmd_idx;
                        lat_nxt   = LAT_RELOAD;
                        state_nxt = READ_LAT;
                    end
                end else if (av_write) begin
                    mem_we   = 1'b1;
                    mem_addr = cmd_idx;
                    if (cmd_n > 5'd1) begin
                        addr_nxt  = cmd_idx + AW'(1);
                        count_nxt = cmd_n - 5'd1;
                        state_nxt = WRITE_BURST;
                    end
                end
            end
            READ_LAT: begin
                if (lat_q == 4'd0) begin
                    mem_re     = 1'b1;
                    loaded_nxt = 1'b1;
                    addr_nxt   = addr_q + AW'(1);
                    state_nxt  = READ_BURST;
                end else begin
                    lat_nxt = lat_q - 4'd1;
                end
            end
            READ_BURST: begin
                if (count_q == 5'd0) begin
                    state_nxt = IDLE;
                end else begin
                    mem_re    = 1'b1;
                    addr_nxt  = addr_q + AW'(1);
                    count_nxt = count_q - 5'd1;
                end
            end
            WRITE_BURST: begin
                if (av_read)
                    err_nxt = 1'b1;
                if (av_write) begin
                    mem_we    = 1'b1;
                    addr_nxt  = addr_q + AW'(1);
                    count_nxt = count_q - 5'd1;
                    if (count_q == 5'd1)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign av_waitrequest   = (state_q == READ_LAT) || (state_q == READ_BURST);
    assign av_readdatavalid = (state_q == READ_BURST);
    assign av_readdata      = loaded_q ? mem_q : 32'd0;
    assign protocol_err     = err_q;

endmodule

// File: tb/tb_avl_burst_mem_slave.sv
// Scoreboard bench for avl_burst_mem_slave: dut0 runs with latency 2, dut1 with latency 1;
// expected beats (data and sampling cycle) are queued at issue and popped by per-DUT monitors.
module tb_avl_burst_mem_slave;

    localparam int D = 4096;
    localparam int LAT [2] = '{2, 1};

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } beat_t;

    logic        clk;
    logic        resetn;
    logic [31:0] address   [2];
    logic        rd        [2];
    logic        wr        [2];
    logic [31:0] writedata [2];
    logic [4:0]  burstcount[2];
    logic        waitreq   [2];
    logic [31:0] readdata  [2];
    logic        valid     [2];
    logic        err       [2];

    beat_t       exp0[$];
    beat_t       exp1[$];
    logic [31:0] model [2][D];
    int          cyc;
    int          n_cmp;
    int          n_fail;

    avl_burst_mem_slave #(.DEPTH_WORDS(D), .INIT_LATENCY(2)) dut0 (
        .clk(clk), .resetn(resetn), .av_address(address[0]), .av_read(rd[0]),
        .av_write(wr[0]), .av_writedata(writedata[0]), .av_burstcount(burstcount[0]),
        .av_waitrequest(waitreq[0]), .av_readdata(readdata[0]),
        .av_readdatavalid(valid[0]), .protocol_err(err[0])
    );

    avl_burst_mem_slave #(.DEPTH_WORDS(D), .INIT_LATENCY(1)) dut1 (
        .clk(clk), .resetn(resetn), .av_address(address[1]), .av_read(rd[1]),
        .av_write(wr[1]), .av_writedata(writedata[1]), .av_burstcount(burstcount[1]),
        .av_waitrequest(waitreq[1]), .av_readdata(readdata[1]),
        .av_readdatavalid(valid[1]), .protocol_err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Monitors: every valid beat must match the head of its DUT's expected queue.
    always @(negedge clk) begin
        beat_t e;
        if (valid[0] === 1'b1) begin
            if (exp0.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL dut0 unexpected beat: got 0x%08h at cycle %0d, required no beat", readdata[0], cyc);
            end else begin
                e = exp0.pop_front();
                check_output("dut0 beat data", readdata[0], e.data);
                check_output("dut0 beat cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (valid[1] === 1'b1) begin
            if (exp1.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL dut1 unexpected beat: got 0x%08h at cycle %0d, required no beat", readdata[1], cyc);
            end else begin
                e = exp1.pop_front();
                check_output("dut1 beat data", readdata[1], e.data);
                check_output("dut1 beat cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle(input int d);
        int guard;
        guard = 0;
        while (waitreq[d] !== 1'b0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (waitreq[d] !== 1'b0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL dut%0d idle timeout: waitrequest %b, required 0", d, waitreq[d]);
        end
    endtask

    task automatic wait_cycle(input int target);
        do @(negedge clk); while (cyc < target);
    endtask

    task automatic apply_read(input int d, input logic [31:0] byte_addr, input logic [4:0] bc,
                              input int push_n, input logic also_write, input logic [31:0] wdata,
                              output int k);
        int    idx;
        int    n;
        beat_t b;
        wait_idle(d);
        address[d]    = byte_addr;
        burstcount[d] = bc;
        writedata[d]  = wdata;
        rd[d]         = 1'b1;
        wr[d]         = also_write;
        @(posedge clk);
        #1;
        k     = cyc;
        rd[d] = 1'b0;
        wr[d] = 1'b0;
        idx   = int'(byte_addr >> 2) % D;
        n     = (bc == 5'd0) ? 1 : int'(bc);
        for (int i = 0; i < n && i < push_n; i++) begin
            b.data = model[d][(idx + i) % D];
            b.cyc  = k + LAT[d] - 1 + i;
            if (d == 0) exp0.push_back(b);
            else        exp1.push_back(b);
        end
    endtask

    task automatic apply_write_burst(input int d, input logic [31:0] byte_addr, input int n,
                                     input logic [31:0] data [32], input int gap_at);
        int idx;
        idx = int'(byte_addr >> 2) % D;
        wait_idle(d);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                wr[d] = 1'b0;
                @(posedge clk);
                #1;
            end
            wr[d]         = 1'b1;
            writedata[d]  = data[i];
            address[d]    = (i == 0) ? byte_addr : 32'hFFFF_FFFC;
            burstcount[d] = (i == 0) ? n[4:0] : 5'd3;
            @(posedge clk);
            #1;
            model[d][(idx + i) % D] = data[i];
        end
        wr[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] buf32 [32];
        int k;
        n_cmp  = 0;
        n_fail = 0;
        resetn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            address[d] = '0; rd[d] = 1'b0; wr[d] = 1'b0;
            writedata[d] = '0; burstcount[d] = '0;
        end
        for (int i = 0; i < 32; i++) buf32[i] = '0;

        repeat (3) @(negedge clk);
        check_output("reset waitrequest", waitreq[0], 0);
        check_output("reset readdatavalid", valid[0], 0);
        check_output("reset readdata", readdata[0], 0);
        check_output("reset protocol_err", err[0], 0);
        resetn = 1'b1;
        @(negedge clk);

        // Preload words 16..31 with i*0x11111111 and the four words around the wrap point.
        for (int i = 0; i < 16; i++) buf32[i] = (16 + i) * 32'h1111_1111;
        apply_write_burst(0, 32'h40, 16, buf32, -1);
        buf32[0] = 32'hA000_0FFE; buf32[1] = 32'hA000_0FFF;
        buf32[2] = 32'hA000_0000; buf32[3] = 32'hA000_0001;
        apply_write_burst(0, (D - 2) * 4, 4, buf32, -1);

        // 16-beat read with a single-cycle request pulse.
        apply_read(0, 32'h40, 5'd16, 32, 1'b0, 32'h0, k);
        wait_cycle(k + 16);
        check_output("waitrequest during last beat", waitreq[0], 1);
        wait_cycle(k + 17);
        check_output("waitrequest after burst", waitreq[0], 0);
        check_output("protocol_err after clean read", err[0], 0);

        // Read across the top of the array.
        apply_read(0, (D - 2) * 4, 5'd4, 32, 1'b0, 32'h0, k);
        wait_cycle(k + 5);
        check_output("readdatavalid after wrap burst", valid[0], 0);
        check_output("readdata holds last beat", readdata[0], 32'hA000_0001);

        // Write burst with an idle beat between B and C, then read it back.
        buf32[0] = 32'hAAAA_0001; buf32[1] = 32'hBBBB_0002;
        buf32[2] = 32'hCCCC_0003; buf32[3] = 32'hDDDD_0004;
        apply_write_burst(0, 32'h100, 4, buf32, 2);
        apply_read(0, 32'h100, 5'd4, 32, 1'b0, 32'h0, k);

        // Read and write together: read served, write dropped, sticky error.
        apply_read(0, 32'h104, 5'd2, 32, 1'b1, 32'hDEAD_BEEF, k);
        wait_idle(0);
        check_output("protocol_err after read+write", err[0], 1);
        apply_read(0, 32'h104, 5'd1, 32, 1'b0, 32'h0, k);
        wait_idle(0);
        check_output("protocol_err stays set", err[0], 1);

        // Reset after beat 5 of a 16-beat read: only beats 0..5 may appear.
        apply_read(0, 32'h40, 5'd16, 6, 1'b0, 32'h0, k);
        wait_cycle(k + 6);
        #2;
        resetn = 1'b0;
        #1;
        check_output("readdatavalid at reset", valid[0], 0);
        check_output("waitrequest at reset", waitreq[0], 0);
        check_output("readdata at reset", readdata[0], 0);
        check_output("protocol_err cleared by reset", err[0], 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        wait_cycle(cyc + 20);
        apply_read(0, 32'h44, 5'd3, 32, 1'b0, 32'h0, k);

        // Latency 1: write then read on the following edge, burstcount 0 means one beat.
        buf32[0] = 32'hCAFE_0001;
        apply_write_burst(1, 32'h8, 1, buf32, -1);
        apply_read(1, 32'h8, 5'd0, 32, 1'b0, 32'h0, k);
        wait_cycle(k + 1);
        check_output("dut1 single beat done", valid[1], 0);
        check_output("dut1 waitrequest low after beat", waitreq[1], 0);

        wait_cycle(cyc + 10);
        check_output("dut0 pending beats", exp0.size(), 0);
        check_output("dut1 pending beats", exp1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
